// File: rtl/hier_leaf_seq_stage.sv
// Sequence-continuity checker feeding a 2-entry skid buffer; words pass through unchanged.
// Latency 1 cycle in->out; registered in_ready drops only when both entries are held.
module hier_leaf_seq_stage #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned LOSS_THR = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              locked,
  output logic              seq_err,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              in_ready_q, in_ready_d;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] expected_q, expected_d;
  logic [3:0]        miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              seq_err_q, seq_err_d;

  logic accept;
  logic drain;

  assign accept    = in_valid & in_ready_q;
  assign out_valid = (count_q != 2'd0);
  assign drain     = out_valid & out_ready;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (accept) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (drain) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({accept, drain})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // Registered ready must reflect occupancy after this cycle's push/pop.
    in_ready_d = (count_d != 2'd2);
  end

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    miss_cnt_d  = miss_cnt_q;
    err_count_d = err_count_q;
    seq_err_d   = 1'b0;
    if (accept) begin
      expected_d = in_data + DATA_W'(1);
      if (state_q == HUNT) begin
        state_d    = LOCK;
        miss_cnt_d = 4'd0;
      end else if (in_data == expected_q) begin
        miss_cnt_d = 4'd0;
      end else begin
        seq_err_d = 1'b1;
        if (err_count_q != {CNT_W{1'b1}}) begin
          err_count_d = err_count_q + CNT_W'(1);
        end
        if (miss_cnt_q == 4'(LOSS_THR - 1)) begin
          state_d    = HUNT;
          miss_cnt_d = 4'd0;
        end else begin
          miss_cnt_d = miss_cnt_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      in_ready_q  <= 1'b0;
      state_q     <= HUNT;
      expected_q  <= '0;
      miss_cnt_q  <= 4'd0;
      err_count_q <= '0;
      seq_err_q   <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      state_q     <= state_d;
      expected_q  <= expected_d;
      miss_cnt_q  <= miss_cnt_d;
      err_count_q <= err_count_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = mem_q[rd_ptr_q];
  assign locked    = (state_q == LOCK);
  assign seq_err   = seq_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_hier_leaf_seq_stage.sv
// Randomized and directed bench for hier_leaf_seq_stage against a queue-based reference model.
// Two instances share stimulus: default parameters, and a 2-bit counter with LOSS_THR=15.
module tb_hier_leaf_seq_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'd0;

  logic       in_ready_a, out_valid_a, locked_a, seq_err_a;
  logic [7:0] out_data_a;
  logic [15:0] err_a;
  logic       in_ready_b, out_valid_b, locked_b, seq_err_b;
  logic [7:0] out_data_b;
  logic [1:0] err_b;

  hier_leaf_seq_stage dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .locked(locked_a), .seq_err(seq_err_a), .err_count(err_a)
  );

  hier_leaf_seq_stage #(.DATA_W(8), .CNT_W(2), .LOSS_THR(15)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .locked(locked_b), .seq_err(seq_err_b), .err_count(err_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: buffer contents as a queue, checker as plain integers.
  byte unsigned q[$];
  bit m_in_ready;
  bit m_out_zero;
  bit m_lock[2];
  int m_exp[2];
  int m_miss[2];
  int m_cnt[2];
  bit m_err[2];
  int cnt_max[2] = '{65535, 3};
  int thr[2]     = '{3, 15};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input int d, input bit ordy);
    bit acc;
    bit drn;
    if (r) begin
      q.delete();
      m_in_ready = 1'b0;
      m_out_zero = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_lock[i] = 1'b0; m_exp[i] = 0; m_miss[i] = 0; m_cnt[i] = 0; m_err[i] = 1'b0;
      end
    end else begin
      acc = v && m_in_ready;
      drn = (q.size() > 0) && ordy;
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(8'(d));
        m_out_zero = 1'b0;
      end
      m_in_ready = (q.size() < 2);
      for (int i = 0; i < 2; i++) begin
        m_err[i] = 1'b0;
        if (acc) begin
          if (!m_lock[i]) begin
            m_lock[i] = 1'b1;
            m_miss[i] = 0;
          end else if (d == m_exp[i]) begin
            m_miss[i] = 0;
          end else begin
            m_err[i] = 1'b1;
            if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
            m_miss[i]++;
            if (m_miss[i] >= thr[i]) begin
              m_lock[i] = 1'b0;
              m_miss[i] = 0;
            end
          end
          m_exp[i] = (d + 1) % 256;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("in_ready_a",  32'(in_ready_a),  32'(m_in_ready));
    chk("in_ready_b",  32'(in_ready_b),  32'(m_in_ready));
    chk("out_valid_a", 32'(out_valid_a), 32'(q.size() > 0));
    chk("out_valid_b", 32'(out_valid_b), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_data_a", 32'(out_data_a), 32'(q[0]));
      chk("out_data_b", 32'(out_data_b), 32'(q[0]));
    end else if (m_out_zero) begin
      chk("out_data_a_rst", 32'(out_data_a), 32'd0);
      chk("out_data_b_rst", 32'(out_data_b), 32'd0);
    end
    chk("locked_a",  32'(locked_a),  32'(m_lock[0]));
    chk("locked_b",  32'(locked_b),  32'(m_lock[1]));
    chk("seq_err_a", 32'(seq_err_a), 32'(m_err[0]));
    chk("seq_err_b", 32'(seq_err_b), 32'(m_err[1]));
    chk("err_a",     32'(err_a),     32'(m_cnt[0]));
    chk("err_b",     32'(err_b),     32'(m_cnt[1]));
  endtask

  task automatic cycle(input bit r, input bit v, input int d, input bit ordy);
    rst       = r;
    in_valid  = v;
    in_data   = 8'(d);
    out_ready = ordy;
    @(posedge clk);
    #1;
    model_step(r, v, d, ordy);
    check_all();
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 0, 1'b0);
    chk("rst_in_ready", 32'(in_ready_a), 32'd0);
    cycle(1'b0, 1'b0, 0, 1'b1);
    chk("post_rst_in_ready", 32'(in_ready_a), 32'd1);
  endtask

  task automatic send(input int words[$]);
    foreach (words[i]) cycle(1'b0, 1'b1, words[i], 1'b1);
    cycle(1'b0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    int nxt;
    bit v;
    int d;

    // Counting sequence
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, i, 1'b1);
    cycle(1'b0, 1'b0, 0, 1'b1);
    chk("t1_locked", 32'(locked_a), 32'd1);
    chk("t1_err", 32'(err_a), 32'd0);

    // Wrap-around
    do_reset();
    send('{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01});
    chk("t2_err", 32'(err_a), 32'd0);

    // Single gap
    do_reset();
    send('{5, 6, 9, 10});
    chk("t3_err", 32'(err_a), 32'd1);
    chk("t3_locked", 32'(locked_a), 32'd1);

    // Loss of lock, then relock
    do_reset();
    send('{1, 2, 7, 3, 8});
    chk("t4_unlocked", 32'(locked_a), 32'd0);
    chk("t4_err", 32'(err_a), 32'd3);
    cycle(1'b0, 1'b1, 20, 1'b1);
    chk("t4_relock", 32'(locked_a), 32'd1);
    chk("t4_relock_noerr", 32'(seq_err_a), 32'd0);

    // Backpressure
    do_reset();
    cycle(1'b0, 1'b1, 10, 1'b0);
    cycle(1'b0, 1'b1, 11, 1'b0);
    cycle(1'b0, 1'b1, 12, 1'b0);
    chk("t5_full_rdy", 32'(in_ready_a), 32'd0);
    chk("t5_hold", 32'(out_data_a), 32'd10);
    cycle(1'b0, 1'b1, 12, 1'b1);
    cycle(1'b0, 1'b1, 12, 1'b1);
    cycle(1'b0, 1'b0, 0, 1'b1);
    cycle(1'b0, 1'b0, 0, 1'b1);
    chk("t5_empty", 32'(out_valid_a), 32'd0);

    // Saturation, then reset mid-stream
    do_reset();
    send('{0, 5, 0, 5, 0, 5, 0});
    chk("t6_sat", 32'(err_b), 32'd3);
    chk("t6_err_a", 32'(err_a), 32'd5);
    chk("t6_locked_b", 32'(locked_b), 32'd1);
    cycle(1'b0, 1'b1, 1, 1'b0);
    cycle(1'b0, 1'b1, 2, 1'b0);
    cycle(1'b1, 1'b1, 3, 1'b0);
    chk("t6_rst_valid", 32'(out_valid_a), 32'd0);
    chk("t6_rst_data", 32'(out_data_a), 32'd0);
    chk("t6_rst_locked", 32'(locked_a), 32'd0);
    chk("t6_rst_err_b", 32'(err_b), 32'd0);
    cycle(1'b0, 1'b0, 0, 1'b1);

    // Randomized traffic: mostly continuous sequence with occasional jumps and resets
    nxt = $urandom_range(0, 255);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        cycle(1'b1, 1'b0, 0, 1'b0);
      end else begin
        v = ($urandom_range(0, 3) != 0);
        d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : nxt;
        if (v && m_in_ready) nxt = (d + 1) % 256;
        cycle(1'b0, v, d, ($urandom_range(0, 2) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
